muldiv_alu_sequencer: RTL and testbench

//  Multi-cycle RV32M sequencer sitting beside the EX stage; time-shares the existing 32-bit ALU
//  (add/sub + carry_flag) to execute MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU iteratively.

---
 rtl/muldiv_alu_sequencer.sv | 231 +++++++++++++++++++++++
 tb/tb_muldiv_alu_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_alu_sequencer.sv
// Iterative RV32M multiply/divide sequencer that time-shares the EX-stage adder (ADD/SUB + carry).
// Optional macro MULDIV_FAST_ZERO_EN: zero multiplicand/multiplier or zero divisor finishes in cycle 2.
module muldiv_alu_sequencer #(
  parameter int         XLEN    = 32,
  parameter logic [3:0] ALU_ADD = 4'd0,
  parameter logic [3:0] ALU_SUB = 4'd1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_sel,
  input  logic [XLEN-1:0] alu_c,
  input  logic            alu_carry
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SIGN_A,
    S_SIGN_B,
    S_ITER,
    S_FIX_LO,
    S_FIX_HI,
    S_DONE
  } state_t;

  state_t          state_reg;
  logic [2:0]      op_reg;
  logic [XLEN-1:0] a_reg;
  logic [XLEN-1:0] b_reg;
  logic [XLEN-1:0] ma_reg;
  logic [XLEN-1:0] mb_reg;
  logic [XLEN-1:0] hi_reg;
  logic [XLEN-1:0] lo_reg;
  logic [CW-1:0]   cnt_reg;
  logic            lo_zero_reg;
  logic            busy_reg;
  logic            done_reg;
  logic [XLEN-1:0] result_reg;

  assign busy   = busy_reg;
  assign done   = done_reg;
  assign result = result_reg;

  // Operation decode, all from the operands latched at acceptance.
  logic            is_div;
  logic            a_signed_op;
  logic            b_signed_op;
  logic            a_s;
  logic            b_s;
  logic            neg_lo;
  logic            neg_hi;
  logic            sel_lo;
  logic            b_zero;
  logic [XLEN-1:0] div_zero_val;
  logic [XLEN-1:0] shifted;
  logic            ge;
  logic [XLEN-1:0] ma_sel;
  logic [XLEN-1:0] mb_sel;
  logic [XLEN-1:0] hi_fixed;
  logic [XLEN-1:0] final_val;

  assign is_div       = op_reg[2];
  assign a_signed_op  = (op_reg == 3'd1) || (op_reg == 3'd2) || (op_reg == 3'd4) || (op_reg == 3'd6);
  assign b_signed_op  = (op_reg == 3'd1) || (op_reg == 3'd4) || (op_reg == 3'd6);
  assign a_s          = a_signed_op & a_reg[XLEN-1];
  assign b_s          = b_signed_op & b_reg[XLEN-1];
  assign neg_lo       = a_s ^ b_s;
  // Remainder takes the dividend's sign; products negate as a whole 64-bit value.
  assign neg_hi       = is_div ? a_s : (a_s ^ b_s);
  assign sel_lo       = (op_reg == 3'd0) || (op_reg == 3'd4) || (op_reg == 3'd5);
  assign b_zero       = (b_reg == '0);
  assign div_zero_val = sel_lo ? '1 : a_reg;

  // Restoring-division step: hi[MSB] is the bit shifted out of the 33-bit partial remainder.
  assign shifted  = {hi_reg[XLEN-2:0], lo_reg[XLEN-1]};
  assign ge       = hi_reg[XLEN-1] | alu_carry;
  assign ma_sel   = a_s ? alu_c : a_reg;
  assign mb_sel   = b_s ? alu_c : b_reg;
  assign hi_fixed = neg_hi ? alu_c : hi_reg;
  assign final_val = (is_div && b_zero) ? div_zero_val : (sel_lo ? lo_reg : hi_fixed);

`ifdef MULDIV_FAST_ZERO_EN
  logic fast_zero;
  assign fast_zero = is_div ? b_zero : ((a_reg == '0) || b_zero);
`endif

  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_sel = ALU_ADD;
    case (state_reg)
      S_SIGN_A: begin
        alu_sel = ALU_SUB;
        alu_b   = a_reg;
      end
      S_SIGN_B: begin
        alu_sel = ALU_SUB;
        alu_b   = b_reg;
      end
      S_ITER: begin
        if (is_div) begin
          alu_sel = ALU_SUB;
          alu_a   = shifted;
          alu_b   = mb_reg;
        end else begin
          alu_sel = ALU_ADD;
          alu_a   = hi_reg;
          alu_b   = lo_reg[0] ? ma_reg : '0;
        end
      end
      S_FIX_LO: begin
        if (neg_lo) begin
          alu_sel = ALU_SUB;
          alu_b   = lo_reg;
        end
      end
      S_FIX_HI: begin
        if (neg_hi) begin
          if (is_div) begin
            alu_sel = ALU_SUB;
            alu_b   = hi_reg;
          end else begin
            // Upper word of a 64-bit two's complement: ~hi plus the borrow-free carry from lo.
            alu_sel = ALU_ADD;
            alu_a   = ~hi_reg;
            alu_b   = {{(XLEN-1){1'b0}}, lo_zero_reg};
          end
        end
      end
      default: begin
        alu_a   = '0;
        alu_b   = '0;
        alu_sel = ALU_ADD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= S_IDLE;
      op_reg      <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      ma_reg      <= '0;
      mb_reg      <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      cnt_reg     <= '0;
      lo_zero_reg <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      result_reg  <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            op_reg    <= op;
            a_reg     <= rs1;
            b_reg     <= rs2;
            busy_reg  <= 1'b1;
            state_reg <= S_SIGN_A;
          end
        end
        S_SIGN_A: begin
          ma_reg    <= ma_sel;
          state_reg <= S_SIGN_B;
`ifdef MULDIV_FAST_ZERO_EN
          if (fast_zero) begin
            result_reg <= is_div ? div_zero_val : '0;
            done_reg   <= 1'b1;
            state_reg  <= S_DONE;
          end
`endif
        end
        S_SIGN_B: begin
          mb_reg    <= mb_sel;
          hi_reg    <= '0;
          lo_reg    <= is_div ? ma_reg : mb_sel;
          cnt_reg   <= '0;
          state_reg <= S_ITER;
        end
        S_ITER: begin
          if (is_div) begin
            hi_reg <= ge ? alu_c : shifted;
            lo_reg <= {lo_reg[XLEN-2:0], ge};
          end else begin
            {hi_reg, lo_reg} <= {alu_carry, alu_c, lo_reg[XLEN-1:1]};
          end
          cnt_reg <= cnt_reg + CW'(1);
          if (cnt_reg == CNT_LAST) begin
            state_reg <= S_FIX_LO;
          end
        end
        S_FIX_LO: begin
          lo_zero_reg <= (lo_reg == '0);
          if (neg_lo) begin
            lo_reg <= alu_c;
          end
          state_reg <= S_FIX_HI;
        end
        S_FIX_HI: begin
          hi_reg     <= hi_fixed;
          result_reg <= final_val;
          done_reg   <= 1'b1;
          state_reg  <= S_DONE;
        end
        S_DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_alu_sequencer.sv
// Scoreboard bench for muldiv_alu_sequencer with a behavioural ADD/SUB ALU attached.
module tb_muldiv_alu_sequencer;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_sel;
  logic [31:0] alu_c;
  logic        alu_carry;
  logic [32:0] alu_sum;

  muldiv_alu_sequencer #(.XLEN(32), .ALU_ADD(ALU_ADD), .ALU_SUB(ALU_SUB)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
    .busy(busy), .done(done), .result(result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_c(alu_c), .alu_carry(alu_carry)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_sum   = {1'b0, alu_a} + {1'b0, alu_b};
    alu_c     = alu_sum[31:0];
    alu_carry = alu_sum[32];
    if (alu_sel == ALU_SUB) begin
      alu_c     = alu_a - alu_b;
      alu_carry = (alu_a >= alu_b) && (alu_b != 32'd0);
    end
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          due;
    int          tag;
  } exp_t;
  exp_t sb[$];

  logic [31:0] hold = '0;
  bit          track_busy = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Edges from acceptance to the cycle where done is high.
  function automatic int lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_FAST_ZERO_EN
    if (o[2] ? (b == 32'd0) : ((a == 32'd0) || (b == 32'd0))) return 1;
`endif
    return 36;
  endfunction

  // Monitor: pops the scoreboard on every done pulse, otherwise checks result holds.
  always @(negedge clk) begin
    exp_t e;
    bit   exp_busy;
    if (!rst) begin
      hold = '0;
    end else begin
      exp_busy = (sb.size() != 0);
      if (track_busy) check("busy", {31'd0, busy}, {31'd0, exp_busy});
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=%h required=no_done", result);
        end else begin
          e = sb.pop_front();
          check("result", result, e.res);
          check("done_cycle", cyc, e.due);
          $display("txn tag=%0d result=%h cycle=%0d", e.tag, result, cyc);
          hold = e.res;
        end
      end else begin
        check("result_hold", result, hold);
      end
    end
  end

  task automatic issue(input int tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input bit keep, input bit push, output int acc);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout actual=busy required=idle tag=%0d", tag);
    end
    op = o;
    rs1 = a;
    rs2 = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    if (push) sb.push_back('{res: res, due: acc + lat(o, a, b), tag: tag});
    if (!keep) start = 1'b0;
    // Scramble the inputs to show the operands were latched.
    op = ~o;
    rs1 = ~a;
    rs2 = b ^ 32'h5A5A_0001;
  endtask

  localparam int NV = 20;
  logic [2:0]  v_op [NV] = '{3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4,
                             3'd6, 3'd0, 3'd7, 3'd5, 3'd1, 3'd0, 3'd5, 3'd3, 3'd1, 3'd0};
  logic [31:0] v_a  [NV] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                             32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd5, 32'h8000_0000,
                             32'h8000_0000, 32'd0, 32'h7B, 32'd100, 32'hFFFF_FFFF,
                             32'h8000_0000, 32'd5, 32'h0001_0000, 32'hFFFF_0000, 32'd12345};
  logic [31:0] v_b  [NV] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
                             32'h8000_0001, 32'h8000_0001, 32'd0, 32'd0, 32'hFFFF_FFFF,
                             32'hFFFF_FFFF, 32'd12345, 32'd0, 32'd7, 32'd1,
                             32'hFFFF_FFFF, 32'd0, 32'h0001_0000, 32'h0001_0000, 32'd0};
  logic [31:0] v_r  [NV] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                             32'd1, 32'h7FFF_FFFE, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000,
                             32'd0, 32'd0, 32'h7B, 32'd14, 32'hFFFF_FFFF,
                             32'h8000_0000, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0};

  initial begin
    int acc;
    int acc2;
    int n;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_alu_sel", {28'd0, alu_sel}, {28'd0, ALU_ADD});
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // MUL 7 * -3, with a stray start mid-iteration that must be ignored.
    issue(0, 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 1'b1, acc);
    repeat (10) @(negedge clk);
    start = 1'b1;
    op = 3'd4;
    @(negedge clk);
    start = 1'b0;

    for (int i = 0; i < NV; i++) begin
      issue(i + 1, v_op[i], v_a[i], v_b[i], v_r[i], 1'b0, 1'b1, acc);
    end

    // Back-to-back with start held high.
    issue(50, 3'd3, 32'h0001_0000, 32'h0001_0000, 32'd1, 1'b1, 1'b1, acc);
    op = 3'd4;
    rs1 = 32'hFFFF_FFF9;
    rs2 = 32'd2;
    issue(51, 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 1'b1, acc2);
    check("b2b_accept_gap", acc2 - acc, 32'd38);

    // Abort: start re-pulsed during ITER, then reset in cycle 20; no done may follow.
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    track_busy = 1'b0;
    issue(99, 3'd0, 32'd7, 32'hFFFF_FFFD, 32'd0, 1'b0, 1'b0, acc);
    repeat (9) @(negedge clk);
    start = 1'b1;
    op = 3'd4;
    @(negedge clk);
    start = 1'b0;
    while (cyc < acc + 19) @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_result", result, 32'd0);
    check("abort_alu_a", alu_a, 32'd0);
    check("abort_alu_b", alu_b, 32'd0);
    check("abort_alu_sel", {28'd0, alu_sel}, {28'd0, ALU_ADD});
    repeat (2) @(negedge clk);
    rst = 1'b1;
    track_busy = 1'b1;
    repeat (45) @(negedge clk);

    issue(100, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, acc);

    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout actual=%0d pending required=0", sb.size());
    end
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
